// File: rtl/spi_slave_gen.sv
// SPI slave with parameterised mode, bit order and word width; back-to-back words while cs stays low.
// Define SPI_SLAVE_GEN_MISO_EN to build the miso transmit shifter; otherwise miso is tied low.
module spi_slave_gen #(
  parameter int DATA_W    = 12,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int LSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  input  logic [DATA_W-1:0] tx_data,
  output logic              miso,
  output logic [DATA_W-1:0] dout,
  output logic              done,
  output logic              busy,
  output logic              err
);

  localparam int               CNT_W          = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT       = CNT_W'(DATA_W - 1);
  localparam logic             SCLK_IDLE      = (CPOL != 0) ? 1'b1 : 1'b0;
  localparam logic             SAMPLE_ON_RISE = (CPOL == CPHA) ? 1'b1 : 1'b0;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  logic sclk_meta_r, sclk_sync_r, sclk_prev_r;
  logic cs_meta_r, cs_sync_r;
  logic mosi_meta_r, mosi_sync_r;
  logic sclk_rise_s, sclk_fall_s, sample_s, shift_s;

  state_t            state_r, state_nx;
  logic [CNT_W-1:0]  cnt_r, cnt_nx;
  logic [DATA_W-1:0] rx_r, rx_nx, rx_shift_s;
  logic [DATA_W-1:0] dout_r, dout_nx;
  logic              done_r, done_nx;
  logic              err_r, err_nx;
  logic              busy_r;

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] word,
                                                 input logic bit_in);
    if (LSB_FIRST != 0) begin
      shift_in = {bit_in, word[DATA_W-1:1]};
    end else begin
      shift_in = {word[DATA_W-2:0], bit_in};
    end
  endfunction

  // Two-flop synchronizers, plus one extra sclk stage for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_meta_r <= SCLK_IDLE;
      sclk_sync_r <= SCLK_IDLE;
      sclk_prev_r <= SCLK_IDLE;
      cs_meta_r   <= 1'b1;
      cs_sync_r   <= 1'b1;
      mosi_meta_r <= 1'b0;
      mosi_sync_r <= 1'b0;
    end else begin
      sclk_meta_r <= sclk;
      sclk_sync_r <= sclk_meta_r;
      sclk_prev_r <= sclk_sync_r;
      cs_meta_r   <= cs;
      cs_sync_r   <= cs_meta_r;
      mosi_meta_r <= mosi;
      mosi_sync_r <= mosi_meta_r;
    end
  end

  assign sclk_rise_s = sclk_sync_r & ~sclk_prev_r;
  assign sclk_fall_s = ~sclk_sync_r & sclk_prev_r;
  assign sample_s    = SAMPLE_ON_RISE ? sclk_rise_s : sclk_fall_s;
  assign shift_s     = SAMPLE_ON_RISE ? sclk_fall_s : sclk_rise_s;
  assign rx_shift_s  = shift_in(rx_r, mosi_sync_r);

  // Next-state and receive-path logic; cs deassertion beats a simultaneous sample edge
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    rx_nx    = rx_r;
    dout_nx  = dout_r;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!cs_sync_r) begin
          state_nx = SHIFT;
          cnt_nx   = {CNT_W{1'b0}};
          rx_nx    = {DATA_W{1'b0}};
        end else begin
          state_nx = IDLE;
        end
      end
      SHIFT: begin
        if (cs_sync_r) begin
          state_nx = IDLE;
          cnt_nx   = {CNT_W{1'b0}};
          rx_nx    = {DATA_W{1'b0}};
          if (cnt_r != {CNT_W{1'b0}}) begin
            err_nx = 1'b1;
          end else begin
            err_nx = 1'b0;
          end
        end else if (sample_s) begin
          rx_nx = rx_shift_s;
          if (cnt_r == LAST_BIT) begin
            dout_nx = rx_shift_s;
            done_nx = 1'b1;
            cnt_nx  = {CNT_W{1'b0}};
          end else begin
            cnt_nx = cnt_r + 1'b1;
          end
        end else begin
          state_nx = SHIFT;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Receive-side state register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      rx_r    <= {DATA_W{1'b0}};
      dout_r  <= {DATA_W{1'b0}};
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
      rx_r    <= rx_nx;
      dout_r  <= dout_nx;
      done_r  <= done_nx;
      err_r   <= err_nx;
      busy_r  <= (state_nx == SHIFT);
    end
  end

  assign dout = dout_r;
  assign done = done_r;
  assign err  = err_r;
  assign busy = busy_r;

`ifdef SPI_SLAVE_GEN_MISO_EN
  logic [DATA_W-1:0] tx_r, tx_nx;
  logic              miso_r, miso_nx;

  function automatic logic first_bit(input logic [DATA_W-1:0] word);
    if (LSB_FIRST != 0) begin
      first_bit = word[0];
    end else begin
      first_bit = word[DATA_W-1];
    end
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] word);
    if (LSB_FIRST != 0) begin
      shift_out = {1'b0, word[DATA_W-1:1]};
    end else begin
      shift_out = {word[DATA_W-2:0], 1'b0};
    end
  endfunction

  // Transmit shifter: CPHA=0 presents the first bit as soon as the frame opens
  always_comb begin
    tx_nx   = tx_r;
    miso_nx = miso_r;
    case (state_r)
      IDLE: begin
        if (!cs_sync_r) begin
          if (CPHA == 0) begin
            miso_nx = first_bit(tx_data);
            tx_nx   = shift_out(tx_data);
          end else begin
            miso_nx = 1'b0;
            tx_nx   = tx_data;
          end
        end else begin
          miso_nx = 1'b0;
        end
      end
      SHIFT: begin
        if (cs_sync_r) begin
          miso_nx = 1'b0;
          tx_nx   = {DATA_W{1'b0}};
        end else if (sample_s && (cnt_r == LAST_BIT)) begin
          tx_nx = tx_data;
        end else if (shift_s) begin
          miso_nx = first_bit(tx_r);
          tx_nx   = shift_out(tx_r);
        end else begin
          tx_nx = tx_r;
        end
      end
      default: begin
        miso_nx = 1'b0;
        tx_nx   = {DATA_W{1'b0}};
      end
    endcase
  end

  // Transmit register and registered miso
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_r   <= {DATA_W{1'b0}};
      miso_r <= 1'b0;
    end else begin
      tx_r   <= tx_nx;
      miso_r <= miso_nx;
    end
  end

  assign miso = miso_r;
`else
  logic unused_s;
  assign unused_s = ^{tx_data, shift_s};
  assign miso     = 1'b0;
`endif

endmodule
